rtos_nios2_oci_dct_ctrl: RTL and testbench
==========================================

RTOS_NIOS2_OCI_DCT_CTRL -- requirements
Module: rtos_nios2_oci_dct_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 7, trace-memory word-address width.
REQ-002 Parameter: OVF_W, default 8, width of the dropped-atom counter.
REQ-003 Port: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port: reset, input, 1, synchronous, active-high reset.
REQ-005 Port: trace_en, input, 1, atom capture enable.
REQ-006 Port: atom_valid, input, 1, a trace atom is present this cycle.
REQ-007 Port: atom, input, 2, direct-compressed-trace atom.
REQ-008 Port: flush_req, input, 1, single-cycle request to emit a partial word.
REQ-009 Port: test_ending, input, 1, end-of-test request: final flush, then halt.
REQ-010 Port: wr_ready, input, 1, trace memory accepts wr_data this cycle.
REQ-011 Port: dct_buffer, output, 30, live collect buffer, 15 two-bit slots.
REQ-012 Port: dct_count, output, 4, number of valid slots in dct_buffer (0-15).
REQ-013 Port: wr_valid, output, 1, a packed word is offered.
REQ-014 Port: wr_data, output, 34, packed word {count[3:0], buffer[29:0]}.
REQ-015 Port: wr_addr, output, ADDR_W, trace-memory address of the offered word.
REQ-016 Port: wrapped, output, 1, sticky flag: the address has wrapped at least once.
REQ-017 Port: ovf_count, output, OVF_W, saturating count of dropped atoms.
REQ-018 Port: test_has_ended, output, 1, controller is halted.

Function
REQ-019 The controller SHALL implement states COLLECT, FLUSH and HALT; COLLECT is the reset state.
REQ-020 An atom SHALL be accepted when atom_valid=1, trace_en=1, state is not HALT and dct_count<15.
- Accepted atom is written to dct_buffer[2*n+1:2*n], n=dct_count.
- dct_count then increments.
REQ-021 An atom SHALL be dropped when atom_valid=1, trace_en=1, state is FLUSH and dct_count=15.
- Each drop increments ovf_count.
- ovf_count saturates at all-ones.
REQ-022 In COLLECT, a word SHALL be launched and the state set to FLUSH on the edge where any of the following holds (n' = count after this cycle's accept):
- n'=15; or
- flush_req=1 and n'>0; or
- test_ending=1 and n'>0.
REQ-023 On launch, the controller SHALL, in the same edge:
- load wr_data with {n', buffer including any atom accepted that cycle};
- set wr_valid=1;
- clear dct_buffer to 0 and dct_count to 0.
- Latency: atom edge to wr_valid is 1 cycle.
REQ-024 In FLUSH, wr_valid, wr_data and wr_addr SHALL remain stable until a handshake (wr_valid=1 and wr_ready=1).
- Atoms continue to be accepted into the cleared buffer while in FLUSH.
REQ-025 On a handshake:
- wr_addr SHALL increment modulo 2^ADDR_W.
- When wr_addr moves from all-ones to 0, wrapped SHALL be set; it stays set until reset.
REQ-026 flush_req asserted while in FLUSH SHALL set a pending flag.
- test_ending asserted while in FLUSH SHALL set an ending flag.
- flush_req in COLLECT with n'=0 SHALL be ignored; no word is launched.
REQ-027 On the handshake edge, the next state SHALL be chosen in this priority order:
- dct_count=15, or the pending flag is set with dct_count>0, or the ending flag is set with dct_count>0: relaunch immediately per REQ-023 and stay in FLUSH (back-to-back words, no idle cycle).
- Otherwise, the ending flag is set: go to HALT.
- Otherwise: go to COLLECT.
- The pending flag clears on the handshake edge.
REQ-028 test_ending in COLLECT with n'=0 SHALL move directly to HALT.
REQ-029 In HALT:
- wr_valid=0 and test_has_ended=1;
- no atoms are accepted or counted as dropped;
- flush_req and test_ending are ignored;
- only reset exits HALT.
REQ-030 trace_en=0 SHALL block atom capture only; flushes, handshakes and halting proceed normally.

Reset
REQ-031 While reset=1 at a clock edge, the controller SHALL enter COLLECT and set:
- dct_buffer=0, dct_count=0;
- wr_valid=0, wr_data=0, wr_addr=0;
- wrapped=0, ovf_count=0, test_has_ended=0;
- pending and ending flags cleared.
REQ-032 Reset asserted during FLUSH or HALT SHALL discard any offered word; no handshake is reported for it.
REQ-033 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-034 Fill: wr_ready=1, 15 consecutive atoms 2'b01 -> one cycle after the 15th atom, wr_valid=1, wr_data={4'hF, 30'h15555555}, wr_addr=0; next edge wr_addr=1, dct_count=0.
REQ-035 Partial flush: atoms 3,2,1, then flush_req -> wr_data={4'd3, 30'h00000000 | 6'b011011}; flush_req with count 0 -> wr_valid stays 0.
REQ-036 Backpressure/overflow: wr_ready=0 during a flush, 20 more atoms -> 15 accepted, ovf_count=5; raise wr_ready -> second full word follows with no idle cycle.
REQ-037 Wrap: ADDR_W=2, 5 full words -> wr_addr sequence 0,1,2,3,0; wrapped=1 from the 4th handshake onward.
REQ-038 End: 4 atoms, then test_ending -> one word with count=4, then test_has_ended=1; further atoms leave dct_count=0 and ovf_count unchanged.
REQ-039 Reset mid-FLUSH: wr_ready=0, reset pulse -> all outputs at reset values; no stale word is reissued.

Source files
------------

// File: rtl/rtos_nios2_oci_dct_ctrl.sv
// rtos_nios2_oci_dct_ctrl: packs 2-bit direct-compressed-trace atoms into 34-bit words for trace memory.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   trace_en            - enables atom capture
//   atom_valid, atom    - incoming trace atom
//   flush_req           - emit a partially filled word
//   test_ending         - final flush, then halt
//   wr_ready            - trace memory accepts the offered word
//   dct_buffer          - live collect buffer, 15 two-bit slots
//   dct_count           - number of valid slots in dct_buffer
//   wr_valid/wr_data    - offered word {count, buffer}
//   wr_addr             - trace-memory address of the offered word
//   wrapped             - sticky: address has wrapped at least once
//   ovf_count           - saturating count of dropped atoms
//   test_has_ended      - controller is halted
module rtos_nios2_oci_dct_ctrl #(
   parameter int ADDR_W = 7,
   parameter int OVF_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trace_en,
   input  logic              atom_valid,
   input  logic [1:0]        atom,
   input  logic              flush_req,
   input  logic              test_ending,
   input  logic              wr_ready,
   output logic [29:0]       dct_buffer,
   output logic [3:0]        dct_count,
   output logic              wr_valid,
   output logic [33:0]       wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wrapped,
   output logic [OVF_W-1:0]  ovf_count,
   output logic              test_has_ended
);
   typedef enum logic [1:0] {COLLECT, FLUSH, HALT} state_t;
   state_t state, state_n;
   logic pending, ending, pending_n, ending_n;
   logic acc, drop, hs, launch, pend_eff, end_eff;
   logic [29:0] buf_acc, buf_n;
   logic [3:0] cnt_acc, cnt_n;
   logic wr_valid_n;
   logic [33:0] wr_data_n;
   assign acc = atom_valid && trace_en && state != HALT && dct_count != 4'd15;
   assign drop = atom_valid && trace_en && state == FLUSH && dct_count == 4'd15;
   assign hs = state == FLUSH && wr_ready;
   // buffer and count as they look after this cycle's accepted atom
   assign buf_acc = acc ? dct_buffer | ({28'd0, atom} << {dct_count, 1'b0}) : dct_buffer;
   assign cnt_acc = dct_count + {3'd0, acc};
   // a request arriving on the same edge counts as if already latched
   assign pend_eff = pending || flush_req;
   assign end_eff = ending || test_ending;
   // flags are always clear in COLLECT, so one launch rule serves both COLLECT and the handshake edge
   assign launch = (state == COLLECT || hs) && (cnt_acc == 4'd15 || ((pend_eff || end_eff) && cnt_acc != 4'd0));
   assign test_has_ended = state == HALT;
   always_comb begin
      state_n = state;
      pending_n = (state == COLLECT || hs) ? 1'b0 : pend_eff;
      ending_n = end_eff;
      wr_valid_n = wr_valid;
      wr_data_n = wr_data;
      buf_n = buf_acc;
      cnt_n = cnt_acc;
      if (launch) begin
         wr_valid_n = 1'b1;
         wr_data_n = {cnt_acc, buf_acc};
         buf_n = '0;
         cnt_n = '0;
         state_n = FLUSH;
      end else if (state == COLLECT && test_ending) begin
         state_n = HALT;
      end else if (hs) begin
         wr_valid_n = 1'b0;
         state_n = end_eff ? HALT : COLLECT;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= COLLECT;
         pending <= 1'b0;
         ending <= 1'b0;
         dct_buffer <= '0;
         dct_count <= '0;
         wr_valid <= 1'b0;
         wr_data <= '0;
         wr_addr <= '0;
         wrapped <= 1'b0;
         ovf_count <= '0;
      end else begin
         state <= state_n;
         pending <= pending_n;
         ending <= ending_n;
         dct_buffer <= buf_n;
         dct_count <= cnt_n;
         wr_valid <= wr_valid_n;
         wr_data <= wr_data_n;
         if (hs) wr_addr <= wr_addr + ADDR_W'(1);
         if (hs && &wr_addr) wrapped <= 1'b1;
         if (drop && !(&ovf_count)) ovf_count <= ovf_count + OVF_W'(1);
      end
   end
endmodule

// File: tb/tb_rtos_nios2_oci_dct_ctrl.sv
// tb_rtos_nios2_oci_dct_ctrl: scoreboard bench for the DCT trace-word packer (ADDR_W=2).
module tb_rtos_nios2_oci_dct_ctrl;
   logic clk = 1'b0;
   logic reset, trace_en, atom_valid, flush_req, test_ending, wr_ready;
   logic [1:0] atom;
   logic [29:0] dct_buffer;
   logic [3:0] dct_count;
   logic wr_valid, wrapped, test_has_ended;
   logic [33:0] wr_data;
   logic [1:0] wr_addr;
   logic [7:0] ovf_count;
   int tests = 0;
   int fails = 0;
   logic [35:0] q[$];
   logic [1:0] nxt_addr;

   rtos_nios2_oci_dct_ctrl #(.ADDR_W(2), .OVF_W(8)) dut (
      .clk(clk), .reset(reset), .trace_en(trace_en), .atom_valid(atom_valid), .atom(atom),
      .flush_req(flush_req), .test_ending(test_ending), .wr_ready(wr_ready),
      .dct_buffer(dct_buffer), .dct_count(dct_count), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_addr(wr_addr), .wrapped(wrapped), .ovf_count(ovf_count), .test_has_ended(test_has_ended)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && wr_valid && wr_ready) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL wr_word: unexpected word addr %0h data %0h", wr_addr, wr_data);
         end else begin
            logic [35:0] e;
            e = q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               fails++;
               $display("FAIL wr_word: got addr %0h data %0h, expected addr %0h data %0h",
                        wr_addr, wr_data, e[35:34], e[33:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [33:0] d);
      q.push_back({nxt_addr, d});
      nxt_addr = nxt_addr + 2'd1;
   endtask

   task automatic send(input logic [1:0] a);
      atom_valid = 1'b1;
      atom = a;
      tick();
      atom_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      atom_valid = 1'b0;
      flush_req = 1'b0;
      test_ending = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      q.delete();
      nxt_addr = 2'd0;
   endtask

   function automatic logic [33:0] full(input logic [1:0] a);
      return {4'hF, {15{a}}};
   endfunction

   initial begin
      trace_en = 1'b1;
      wr_ready = 1'b1;
      atom = 2'd0;
      do_reset();
      chk("rst_buffer", dct_buffer, 0);
      chk("rst_count", dct_count, 0);
      chk("rst_valid", wr_valid, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_addr", wr_addr, 0);
      chk("rst_wrapped", wrapped, 0);
      chk("rst_ovf", ovf_count, 0);
      chk("rst_ended", test_has_ended, 0);

      // fill: 15 atoms of 01
      push({4'hF, 30'h15555555});
      for (int i = 0; i < 15; i++) begin
         send(2'b01);
         if (i == 6) chk("fill_count7", dct_count, 7);
      end
      chk("fill_valid", wr_valid, 1);
      chk("fill_data", wr_data, {4'hF, 30'h15555555});
      chk("fill_addr", wr_addr, 0);
      tick();
      chk("fill_addr_next", wr_addr, 1);
      chk("fill_count0", dct_count, 0);

      // partial flush: atoms 3,2,1
      send(2'd3);
      send(2'd2);
      send(2'd1);
      chk("part_buffer", dct_buffer, 30'h1B);
      push({4'd3, 30'h1B});
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      chk("part_data", wr_data, {4'd3, 30'h1B});
      tick();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      chk("empty_flush_valid", wr_valid, 0);
      chk("empty_flush_addr", wr_addr, 2);

      // backpressure and overflow
      wr_ready = 1'b0;
      push(full(2'b10));
      for (int i = 0; i < 15; i++) send(2'b10);
      push(full(2'b11));
      for (int i = 0; i < 20; i++) send(2'b11);
      chk("bp_count", dct_count, 15);
      chk("bp_ovf", ovf_count, 5);
      chk("bp_data_stable", wr_data, full(2'b10));
      chk("bp_addr_stable", wr_addr, 2);
      wr_ready = 1'b1;
      tick();
      chk("bp_b2b_valid", wr_valid, 1);
      chk("bp_b2b_data", wr_data, full(2'b11));
      chk("bp_b2b_addr", wr_addr, 3);
      chk("bp_wrapped0", wrapped, 0);
      tick();
      chk("bp_wrap_addr", wr_addr, 0);
      chk("bp_wrapped1", wrapped, 1);
      chk("bp_valid_done", wr_valid, 0);

      // wrap: 5 streamed full words
      do_reset();
      for (int k = 0; k < 75; k++) begin
         logic [1:0] a;
         a = 2'((k / 15 + 1) % 4);
         if (k % 15 == 0) push(full(a));
         send(a);
         if (k == 59) begin
            chk("wrap_addr3", wr_addr, 3);
            chk("wrap_before", wrapped, 0);
         end
         if (k == 60) begin
            chk("wrap_addr0", wr_addr, 0);
            chk("wrap_after", wrapped, 1);
         end
      end
      tick();
      chk("wrap_final_addr", wr_addr, 1);
      chk("wrap_sticky", wrapped, 1);

      // pending flush during backpressure relaunches back-to-back
      wr_ready = 1'b0;
      push(full(2'b01));
      for (int i = 0; i < 15; i++) send(2'b01);
      send(2'd2);
      send(2'd3);
      send(2'd1);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      push({4'd3, 30'h1E});
      wr_ready = 1'b1;
      tick();
      chk("pend_valid", wr_valid, 1);
      chk("pend_data", wr_data, {4'd3, 30'h1E});
      tick();
      chk("pend_done", wr_valid, 0);

      // test ending with a partial word
      for (int i = 0; i < 4; i++) send(2'b01);
      push({4'd4, 30'h55});
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      chk("end_valid", wr_valid, 1);
      chk("end_not_halted", test_has_ended, 0);
      tick();
      chk("end_halted", test_has_ended, 1);
      chk("end_valid0", wr_valid, 0);
      for (int i = 0; i < 5; i++) send(2'b11);
      chk("halt_count", dct_count, 0);
      chk("halt_ovf", ovf_count, 0);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      chk("halt_flush_valid", wr_valid, 0);
      chk("halt_sticky", test_has_ended, 1);

      // test ending with empty buffer halts directly
      do_reset();
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      chk("end_empty_halted", test_has_ended, 1);
      chk("end_empty_valid", wr_valid, 0);

      // reset during FLUSH drops the offered word
      do_reset();
      wr_ready = 1'b0;
      for (int i = 0; i < 15; i++) send(2'b01);
      chk("midrst_valid_pre", wr_valid, 1);
      do_reset();
      chk("midrst_valid", wr_valid, 0);
      chk("midrst_data", wr_data, 0);
      chk("midrst_addr", wr_addr, 0);
      chk("midrst_count", dct_count, 0);
      chk("midrst_buffer", dct_buffer, 0);
      wr_ready = 1'b1;
      repeat (3) tick();
      chk("midrst_no_reissue", wr_valid, 0);
      chk("midrst_addr_hold", wr_addr, 0);

      chk("sb_drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
